// File: rtl/ps2_key_rx_if.sv
// Output bundle of the PS/2 key receiver: decoded key word, raw byte strobe and error pulse.
// The receiver drives it through the master modport; core logic reads it through slave.
interface ps2_key_rx_if;
    logic [10:0] ps2_key;
    logic [7:0]  rx_byte;
    logic        rx_stb;
    logic        err;

    modport master (output ps2_key, rx_byte, rx_stb, err);
    modport slave  (input  ps2_key, rx_byte, rx_stb, err);
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host receiver: synchronise and filter the line, deframe 11-bit frames,
// then fold Set-2 prefixes (E0/F0/E1) into the toggle-strobe key word.
module ps2_key_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SKIP_PAUSE     = 7
) (
    input  logic          CLK_50M,
    input  logic          RESET,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    ps2_key_rx_if.master  o_key_if
);
    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = (SKIP_PAUSE > 1) ? $clog2(SKIP_PAUSE + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t         r_state, w_state_nxt;
    logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic           r_clk_f, r_clk_f_d;
    logic [FW-1:0]  r_filt_cnt;
    logic [TW-1:0]  r_to_cnt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_par_ok;
    logic [10:0]    r_key;
    logic [7:0]     r_rx_byte;
    logic           r_rx_stb, r_err;
    logic           r_ext, r_rel;
    logic [SW-1:0]  r_skip;
    logic           w_fall, w_timeout, w_accept, w_frame_err, w_err;

    assign w_fall    = r_clk_f_d & ~r_clk_f;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_err     = w_frame_err | w_timeout;

    // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_f    <= 1'b1;
            r_clk_f_d  <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1  <= ps2_clk_in;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= ps2_data_in;
            r_dat_s2  <= r_dat_s1;
            r_clk_f_d <= r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_f    <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET || w_fall || r_state == S_IDLE) r_to_cnt <= '0;
        else                                      r_to_cnt <= r_to_cnt + 1'b1;
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_frame_err = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (r_dat_s2 && r_par_ok) w_accept    = 1'b1;
                    else                      w_frame_err = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_bit_cnt <= '0;
            r_par_ok  <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: r_bit_cnt <= '0;
                S_DATA: begin
                    r_shift   <= {r_dat_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                S_PARITY: r_par_ok <= ^{r_shift, r_dat_s2};
                default: ;
            endcase
        end
    end

    // Byte lands one cycle after the stop edge; the decode runs one cycle later off rx_stb.
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_key     <= '0;
            r_rx_byte <= '0;
            r_rx_stb  <= 1'b0;
            r_err     <= 1'b0;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_skip    <= '0;
        end else begin
            r_rx_stb <= w_accept;
            r_err    <= w_err;
            if (w_accept) r_rx_byte <= r_shift;
            if (w_err) begin
                r_ext  <= 1'b0;
                r_rel  <= 1'b0;
                r_skip <= '0;
            end else if (r_rx_stb) begin
                if (r_skip != '0) begin
                    r_skip <= r_skip - 1'b1;
                end else begin
                    case (r_rx_byte)
                        8'hE1: r_skip <= SW'(SKIP_PAUSE);
                        8'hE0: r_ext  <= 1'b1;
                        8'hF0: r_rel  <= 1'b1;
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
                            r_ext <= 1'b0;
                            r_rel <= 1'b0;
                        end
                        default: begin
                            r_key <= {~r_key[10], ~r_rel, r_ext, r_rx_byte};
                            r_ext <= 1'b0;
                            r_rel <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign o_key_if.ps2_key = r_key;
    assign o_key_if.rx_byte = r_rx_byte;
    assign o_key_if.rx_stb  = r_rx_stb;
    assign o_key_if.err     = r_err;
endmodule
